sprite_dma_ctrl: RTL

SPRITE_DMA_CTRL -- requirements
Module: sprite_dma_ctrl

---
 rtl/sprite_dma_ctrl.sv | 119 +++++++++++
 1 files changed

// File: rtl/sprite_dma_ctrl.sv
// Sprite DMA controller: a CPU write to DMA_REG_ADDR pauses the CPU and copies one 256-byte page into OAM.
// Optional macro SPRITE_DMA_ODD_ALIGN_EN adds the odd-cycle ALIGN state before the first read.
module sprite_dma_ctrl #(
  parameter logic [15:0] DMA_REG_ADDR  = 16'h4014,
  parameter logic [15:0] OAM_DATA_ADDR = 16'h2004
) (
  input  logic        i_CLK,
  input  logic        i_RST,
  input  logic [15:0] i_CPU_ADDR,
  input  logic [7:0]  i_CPU_DATA,
  input  logic        i_CPU_R_WN,
  input  logic [7:0]  i_BUS_DATA,
  output logic        o_PAUSE,
  output logic [15:0] o_BUS_ADDR,
  output logic [7:0]  o_BUS_DATA,
  output logic        o_BUS_R_WN
);

  // state  | meaning
  // IDLE   | CPU owns the bus, watching for the trigger write
  // HALT   | first paused cycle, dummy read at the CPU address
  // ALIGN  | extra dummy read to land READ on the proper cycle parity
  // READ   | fetch source byte {page, cnt}
  // WRITE  | store fetched byte to the OAM data port
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_HALT  = 3'd1,
`ifdef SPRITE_DMA_ODD_ALIGN_EN
    ST_ALIGN = 3'd2,
`endif
    ST_READ  = 3'd3,
    ST_WRITE = 3'd4
  } state_t;

  state_t     state_q;
  logic [7:0] page_q;
  logic [7:0] cnt_q;
  logic [7:0] byte_q;
`ifdef SPRITE_DMA_ODD_ALIGN_EN
  logic       odd_q;
`endif

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      state_q <= ST_IDLE;
      page_q  <= 8'h00;
      cnt_q   <= 8'h00;
      byte_q  <= 8'h00;
`ifdef SPRITE_DMA_ODD_ALIGN_EN
      odd_q   <= 1'b0;
`endif
    end else begin
`ifdef SPRITE_DMA_ODD_ALIGN_EN
      odd_q <= ~odd_q;
`endif
      case (state_q)
        ST_IDLE: begin
          if (!i_CPU_R_WN && (i_CPU_ADDR == DMA_REG_ADDR)) begin
            page_q  <= i_CPU_DATA;
            cnt_q   <= 8'h00;
            state_q <= ST_HALT;
          end
        end
        ST_HALT: begin
`ifdef SPRITE_DMA_ODD_ALIGN_EN
          state_q <= odd_q ? ST_ALIGN : ST_READ;
`else
          state_q <= ST_READ;
`endif
        end
`ifdef SPRITE_DMA_ODD_ALIGN_EN
        ST_ALIGN: state_q <= ST_READ;
`endif
        ST_READ: begin
          byte_q  <= i_BUS_DATA;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          cnt_q   <= cnt_q + 8'h01;
          state_q <= (cnt_q == 8'hFF) ? ST_IDLE : ST_READ;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_PAUSE = (state_q != ST_IDLE);

  // Bus mux stays combinational so the CPU sees a true pass-through in IDLE.
  always_comb begin
    o_BUS_ADDR = i_CPU_ADDR;
    o_BUS_DATA = i_CPU_DATA;
    o_BUS_R_WN = i_CPU_R_WN;
    case (state_q)
      ST_HALT: begin
        o_BUS_R_WN = 1'b1;
        o_BUS_DATA = 8'h00;
      end
`ifdef SPRITE_DMA_ODD_ALIGN_EN
      ST_ALIGN: begin
        o_BUS_R_WN = 1'b1;
        o_BUS_DATA = 8'h00;
      end
`endif
      ST_READ: begin
        o_BUS_ADDR = {page_q, cnt_q};
        o_BUS_DATA = 8'h00;
        o_BUS_R_WN = 1'b1;
      end
      ST_WRITE: begin
        o_BUS_ADDR = OAM_DATA_ADDR;
        o_BUS_DATA = byte_q;
        o_BUS_R_WN = 1'b0;
      end
      default: ;
    endcase
  end

endmodule
